// File: rtl/bayer_window.sv
// bayer_window: 3x3 raw Bayer window built from raster pixels over two line buffers; BAYER_WINDOW_COORD_EN adds oX/oY.
// Latency 1 cycle from accepted pixel to oDVAL; no backpressure, iDVAL gaps simply hold the window.
module bayer_window #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iFVAL,
  input  logic        iDVAL,
  input  logic [11:0] iDATA,
  output logic [11:0] oP_0,
  output logic [11:0] oP_1,
  output logic [11:0] oP_2,
  output logic [11:0] oP_3,
  output logic [11:0] oP_4,
  output logic [11:0] oP_5,
  output logic [11:0] oP_6,
  output logic [11:0] oP_7,
  output logic [11:0] oP_8,
  output logic        oX_LSB,
  output logic        oY_LSB,
`ifdef BAYER_WINDOW_COORD_EN
  output logic [10:0] oX,
  output logic [10:0] oY,
`endif
  output logic        oDVAL
);
  localparam int          AW       = $clog2(IMG_WIDTH);
  localparam logic [10:0] LAST_COL = 11'(IMG_WIDTH - 1);
  localparam logic [10:0] N_ROWS   = 11'(IMG_HEIGHT);

  logic [10:0]   r_col;
  logic [10:0]   r_row;
  logic          r_armed;
  logic [11:0]   r_lb1 [IMG_WIDTH];
  logic [11:0]   r_lb2 [IMG_WIDTH];
  logic [11:0]   r_win [9];
  logic          r_dval;
  logic          r_x_lsb;
  logic          r_y_lsb;

  logic          w_accept;
  logic          w_win_ok;
  logic [AW-1:0] w_addr;
  logic [11:0]   w_lb1;
  logic [11:0]   w_lb2;

  // r_armed blocks a frame that was cut by reset until a clean frame boundary is seen
  assign w_accept = iFVAL & iDVAL & r_armed & (r_row < N_ROWS);
  assign w_win_ok = w_accept & (r_row >= 11'd2) & (r_col >= 11'd2);
  assign w_addr   = r_col[AW-1:0];
  assign w_lb1    = r_lb1[w_addr];
  assign w_lb2    = r_lb2[w_addr];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_armed <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
    end else if (!iFVAL) begin
      r_armed <= 1'b1;
      r_col   <= '0;
      r_row   <= '0;
    end else if (w_accept) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= r_row + 11'd1;
      end else begin
        r_col <= r_col + 11'd1;
      end
    end
  end

  // Line buffers are plain storage: never reset, stale rows are never inside an emitted window
  always_ff @(posedge iCLK) begin
    if (w_accept) begin
      r_lb1[w_addr] <= iDATA;
      r_lb2[w_addr] <= w_lb1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
      r_dval  <= 1'b0;
      r_x_lsb <= 1'b0;
      r_y_lsb <= 1'b0;
    end else begin
      r_dval <= w_win_ok;
      if (w_accept) begin
        r_win[2] <= r_win[1];
        r_win[1] <= r_win[0];
        r_win[0] <= w_lb2;
        r_win[5] <= r_win[4];
        r_win[4] <= r_win[3];
        r_win[3] <= w_lb1;
        r_win[8] <= r_win[7];
        r_win[7] <= r_win[6];
        r_win[6] <= iDATA;
      end
      // centre sits one column and one row behind the incoming pixel
      if (w_win_ok) begin
        r_x_lsb <= ~r_col[0];
        r_y_lsb <= ~r_row[0];
      end
    end
  end

`ifdef BAYER_WINDOW_COORD_EN
  logic [10:0] r_x;
  logic [10:0] r_y;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_win_ok) begin
      r_x <= r_col - 11'd1;
      r_y <= r_row - 11'd1;
    end
  end

  assign oX = r_x;
  assign oY = r_y;
`endif

  assign oP_0   = r_win[0];
  assign oP_1   = r_win[1];
  assign oP_2   = r_win[2];
  assign oP_3   = r_win[3];
  assign oP_4   = r_win[4];
  assign oP_5   = r_win[5];
  assign oP_6   = r_win[6];
  assign oP_7   = r_win[7];
  assign oP_8   = r_win[8];
  assign oX_LSB = r_x_lsb;
  assign oY_LSB = r_y_lsb;
  assign oDVAL  = r_dval;

endmodule

// File: tb/tb_bayer_window.sv
// Bench for bayer_window at 8x6: frame-image model predicts each window, one negedge compare process checks every cycle.
module tb_bayer_window;
  localparam int W = 8;
  localparam int H = 6;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iFVAL = 1'b0;
  logic        iDVAL = 1'b0;
  logic [11:0] iDATA = '0;
  logic [11:0] oP_0, oP_1, oP_2, oP_3, oP_4, oP_5, oP_6, oP_7, oP_8;
  logic        oX_LSB, oY_LSB, oDVAL;
`ifdef BAYER_WINDOW_COORD_EN
  logic [10:0] oX, oY;
`endif

  bayer_window #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iFVAL(iFVAL), .iDVAL(iDVAL), .iDATA(iDATA),
    .oP_0(oP_0), .oP_1(oP_1), .oP_2(oP_2), .oP_3(oP_3), .oP_4(oP_4),
    .oP_5(oP_5), .oP_6(oP_6), .oP_7(oP_7), .oP_8(oP_8),
    .oX_LSB(oX_LSB), .oY_LSB(oY_LSB),
`ifdef BAYER_WINDOW_COORD_EN
    .oX(oX), .oY(oY),
`endif
    .oDVAL(oDVAL)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  logic [11:0] op [9];
  assign op[0] = oP_0;
  assign op[1] = oP_1;
  assign op[2] = oP_2;
  assign op[3] = oP_3;
  assign op[4] = oP_4;
  assign op[5] = oP_5;
  assign op[6] = oP_6;
  assign op[7] = oP_7;
  assign op[8] = oP_8;

  typedef struct {
    int due;
    bit win;
    int r;
    int c;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  bit   hold_ok = 1'b0;
  int   hr = 0;
  int   hc = 0;
  exp_t e;

  function automatic int pix(input int r, input int c);
    return r * 64 + c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Window for newest accepted pixel (r,c): row group k/3 from top, column offset k%3 from the newest
  task automatic check_window(input string tag, input int r, input int c);
    for (int k = 0; k < 9; k++)
      chk($sformatf("%s_p%0d(%0d,%0d)", tag, k, r, c), int'(op[k]), pix(r - 2 + k / 3, c - k % 3));
    chk($sformatf("%s_xlsb", tag), int'(oX_LSB), (c - 1) & 1);
    chk($sformatf("%s_ylsb", tag), int'(oY_LSB), (r - 1) & 1);
`ifdef BAYER_WINDOW_COORD_EN
    chk($sformatf("%s_x", tag), int'(oX), c - 1);
    chk($sformatf("%s_y", tag), int'(oY), r - 1);
`endif
    if (r == 2 && c == 2) begin
      chk("pin22_p0", int'(oP_0), 2);
      chk("pin22_p1", int'(oP_1), 1);
      chk("pin22_p2", int'(oP_2), 0);
      chk("pin22_p4", int'(oP_4), 65);
      chk("pin22_p6", int'(oP_6), 130);
      chk("pin22_p8", int'(oP_8), 128);
      chk("pin22_xlsb", int'(oX_LSB), 1);
      chk("pin22_ylsb", int'(oY_LSB), 1);
    end
    if (r == 3 && c == 4) begin
      chk("pin34_p4", int'(oP_4), 131);
      chk("pin34_p3", int'(oP_3), 132);
      chk("pin34_p7", int'(oP_7), 195);
      chk("pin34_xlsb", int'(oX_LSB), 1);
      chk("pin34_ylsb", int'(oY_LSB), 0);
`ifdef BAYER_WINDOW_COORD_EN
      chk("pin34_x", int'(oX), 3);
      chk("pin34_y", int'(oY), 2);
`endif
    end
  endtask

  always @(negedge iCLK) begin
    if (!iRST_N) begin
      hold_ok = 1'b0;
      q.delete();
    end else begin
      while (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        chk("missed_slot", 0, 1);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk($sformatf("dval(%0d,%0d)", e.r, e.c), int'(oDVAL), int'(e.win));
        if (e.win) begin
          pulses++;
          check_window("win", e.r, e.c);
          hold_ok = 1'b1;
          hr = e.r;
          hc = e.c;
        end else begin
          hold_ok = 1'b0;
        end
      end else begin
        chk("dval_idle", int'(oDVAL), 0);
        if (hold_ok) check_window("hold", hr, hc);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 9; k++) chk($sformatf("%s_p%0d", tag, k), int'(op[k]), 0);
    chk($sformatf("%s_xlsb", tag), int'(oX_LSB), 0);
    chk($sformatf("%s_ylsb", tag), int'(oY_LSB), 0);
    chk($sformatf("%s_dval", tag), int'(oDVAL), 0);
`ifdef BAYER_WINDOW_COORD_EN
    chk($sformatf("%s_x", tag), int'(oX), 0);
    chk($sformatf("%s_y", tag), int'(oY), 0);
`endif
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(posedge iCLK); #1;
      iDVAL = 1'b0;
    end
  endtask

  task automatic send_px(input int r, input int c, input bit acc);
    exp_t x;
    @(posedge iCLK); #1;
    iFVAL = 1'b1;
    iDVAL = 1'b1;
    iDATA = 12'(pix(r, c));
    if (acc) begin
      x.due = cyc + 1;
      x.win = (r >= 2 && c >= 2);
      x.r   = r;
      x.c   = c;
      q.push_back(x);
    end
  endtask

  task automatic end_frame();
    @(posedge iCLK); #1;
    iDVAL = 1'b0;
    iFVAL = 1'b0;
    repeat (4) @(posedge iCLK);
    #1;
  endtask

  task automatic send_frame(input string tag, input int nlines, input bit gaps, input int want);
    int p0;
    p0 = pulses;
    for (int r = 0; r < nlines; r++)
      for (int c = 0; c < W; c++) begin
        send_px(r, c, r < H);
        if (gaps) drive_idle($urandom_range(0, 5));
      end
    end_frame();
    chk($sformatf("%s_pulses", tag), pulses - p0, want);
  endtask

  initial begin
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    check_reset_outputs("por");
    @(posedge iCLK); #1;
    iRST_N = 1'b1;
    drive_idle(2);

    send_frame("cont", H, 1'b0, 24);
    send_frame("gaps", H, 1'b1, 24);

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++)
        if (r < 3 || c < 4) send_px(r, c, 1'b1);
    @(posedge iCLK); #1;
    iDVAL  = 1'b0;
    iRST_N = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge iCLK);
    #1;
    iRST_N = 1'b1;
    for (int r = 3; r < H; r++)
      for (int c = (r == 3) ? 4 : 0; c < W; c++) send_px(r, c, 1'b0);
    end_frame();
    send_frame("after_rst", H, 1'b0, 24);

    send_frame("tall", H + 1, 1'b0, 24);
    send_frame("short", 4, 1'b0, 12);
    send_frame("after_short", H, 1'b1, 24);

    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
